// File: rtl/pixel_fb_writer.sv
// Pixel-stream sink: clips and linearises (x, y, colour) beats, buffers them in a small FIFO
// and writes them to the framebuffer. Optional full-screen clear is enabled by CLEAR_SCREEN_EN.
module pixel_fb_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [8:0]    x_stream,
    input  logic [7:0]    y_stream,
    input  logic [2:0]    color_stream,
    input  logic          writeEn,
    output logic          in_ready,
    input  logic          flush_req,
    output logic          flush_done,
    output logic [16:0]   mem_addr,
    output logic [2:0]    mem_wdata,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic          overflow,
    output logic [7:0]    drop_count,
    output logic [AW:0]   fill
`ifdef CLEAR_SCREEN_EN
    ,
    input  logic          clear_req,
    input  logic [2:0]    clear_color,
    output logic          clear_busy
`endif
);

    localparam logic [16:0] SCR_W17   = 17'(SCREEN_W);
    localparam logic [16:0] SCR_H17   = 17'(SCREEN_H);
    localparam logic [16:0] LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

`ifdef CLEAR_SCREEN_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE, ST_CLEAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;
`endif

    state_t       state_q;
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [19:0]  fifo_q [DEPTH];
    logic [19:0]  last_q;
    logic         overflow_q;
    logic [7:0]   drop_q;

    logic         empty, full, in_range, push, pop, clearing;
    logic [16:0]  push_addr;
    logic [19:0]  head;

`ifdef CLEAR_SCREEN_EN
    logic         clear_req_q, clear_pend_q;
    logic [16:0]  clr_addr_q;
    assign clearing   = (state_q == ST_CLEAR);
    assign clear_busy = clearing;
`else
    assign clearing   = 1'b0;
`endif

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_range  = ({8'd0, x_stream} < SCR_W17) && ({9'd0, y_stream} < SCR_H17);
    assign in_ready  = !full && !clearing;
    assign push      = writeEn && in_range && in_ready;
    assign pop       = !empty && mem_ready;
    assign push_addr = {9'd0, y_stream} * SCR_W17 + {8'd0, x_stream};
    assign head      = fifo_q[rd_ptr_q[AW-1:0]];

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign flush_done = (state_q == ST_DONE);

    // Outputs show the FIFO head, or the last written pixel once the FIFO runs dry.
    always_comb begin
        mem_we    = !empty;
        mem_addr  = empty ? last_q[19:3] : head[19:3];
        mem_wdata = empty ? last_q[2:0]  : head[2:0];
`ifdef CLEAR_SCREEN_EN
        if (clearing) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = clear_color;
        end
`endif
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {push_addr, color_stream};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
`ifdef CLEAR_SCREEN_EN
            clear_req_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            clr_addr_q   <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= head;
            end
            if (writeEn && in_range && !in_ready) begin
                overflow_q <= 1'b1;
            end
            if (writeEn && !in_range && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
`ifdef CLEAR_SCREEN_EN
            clear_req_q <= clear_req;
            if ((state_q == ST_IDLE) && clear_req && !clear_req_q) begin
                clear_pend_q <= 1'b1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q <= ST_DRAIN;
`ifdef CLEAR_SCREEN_EN
                        clear_pend_q <= 1'b0;
`endif
                    end
`ifdef CLEAR_SCREEN_EN
                    else if (clear_pend_q && empty) begin
                        state_q      <= ST_CLEAR;
                        clear_pend_q <= 1'b0;
                        clr_addr_q   <= '0;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (empty && !push) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (push) begin
                        state_q <= ST_DRAIN;
                    end else if (!flush_req) begin
                        state_q <= ST_IDLE;
                    end
                end
`ifdef CLEAR_SCREEN_EN
                ST_CLEAR: begin
                    if (mem_ready) begin
                        last_q <= {clr_addr_q, clear_color};
                        if (clr_addr_q == LAST_ADDR) begin
                            state_q <= ST_IDLE;
                        end else begin
                            clr_addr_q <= clr_addr_q + 17'd1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer: expected writes are queued as beats are driven and
// compared as the framebuffer port accepts them.
module tb_pixel_fb_writer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [8:0]  x_stream = '0;
    logic [7:0]  y_stream = '0;
    logic [2:0]  color_stream = '0;
    logic        writeEn = 1'b0;
    logic        in_ready;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [16:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [3:0]  fill;
    logic        busy;
`ifdef CLEAR_SCREEN_EN
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        clear_busy;
    assign busy = clear_busy;
`else
    assign busy = 1'b0;
`endif

    pixel_fb_writer #(.DEPTH(DEPTH), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .x_stream     (x_stream),
        .y_stream     (y_stream),
        .color_stream (color_stream),
        .writeEn      (writeEn),
        .in_ready     (in_ready),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .fill         (fill)
`ifdef CLEAR_SCREEN_EN
        ,
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy)
`endif
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int writes = 0;
    int last_wr_edge = -1;
    int exp_drop = 0;
    bit exp_ovf = 1'b0;
    logic [16:0] last_addr = '0;
    logic [19:0] sb_q[$];
    int clr_writes = 0;
    int clr_bad = 0;
    logic [16:0] clr_exp = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    // A write seen here completes at the coming rising edge.
    always @(negedge clk) begin
        logic [19:0] e;
        if (resetn && mem_we && mem_ready && !busy) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", 32'(mem_addr), 32'h1FFFF);
            end else begin
                e = sb_q.pop_front();
                $display("write addr=%0d data=%0d (expected %0d/%0d)", mem_addr, mem_wdata, e[19:3], e[2:0]);
                check_eq("wr_addr", 32'(mem_addr), 32'(e[19:3]));
                check_eq("wr_data", 32'(mem_wdata), 32'(e[2:0]));
            end
            writes++;
            last_addr = mem_addr;
            last_wr_edge = cyc + 1;
        end
`ifdef CLEAR_SCREEN_EN
        if (resetn && busy && mem_we && mem_ready) begin
            if (mem_addr !== clr_exp || mem_wdata !== clear_color) clr_bad++;
            clr_exp = clr_exp + 17'd1;
            clr_writes++;
        end
`endif
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one beat for exactly one edge and records what the design must do with it.
    task automatic drive_beat(input int x, input int y, input int c);
        x_stream = 9'(x);
        y_stream = 8'(y);
        color_stream = 3'(c);
        writeEn = 1'b1;
        if (x < 320 && y < 240) begin
            if (sb_q.size() < DEPTH) sb_q.push_back({17'(y * 320 + x), 3'(c)});
            else exp_ovf = 1'b1;
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        @(posedge clk);
        #1;
        writeEn = 1'b0;
    endtask

    initial begin
        int w0;
        int first_fd;
        int n;

        tick(3);
        resetn = 1'b1;
        tick(1);
        check_eq("rst_we", 32'(mem_we), 0);
        check_eq("rst_addr", 32'(mem_addr), 0);
        check_eq("rst_wdata", 32'(mem_wdata), 0);
        check_eq("rst_fill", 32'(fill), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_drop", 32'(drop_count), 0);
        check_eq("rst_flush_done", 32'(flush_done), 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);

        // Single beat, one-cycle latency to mem_we.
        mem_ready = 1'b1;
        drive_beat(5, 2, 3);
        check_eq("single_we", 32'(mem_we), 1);
        check_eq("single_addr", 32'(mem_addr), 645);
        check_eq("single_fill", 32'(fill), 1);
        tick(1);
        check_eq("single_fill_after", 32'(fill), 0);
        check_eq("single_we_after", 32'(mem_we), 0);
        check_eq("single_addr_hold", 32'(mem_addr), 645);

        // Off-screen beats are clipped.
        drive_beat(320, 0, 1);
        drive_beat(0, 240, 2);
        tick(1);
        check_eq("clip_drop", 32'(drop_count), 32'(exp_drop));
        check_eq("clip_overflow", 32'(overflow), 0);
        check_eq("clip_we", 32'(mem_we), 0);

        // Back-to-back stream ending at the last pixel.
        w0 = writes;
        for (int i = 0; i < 100; i++) drive_beat(220 + i, 239, i % 8);
        tick(2);
        check_eq("stream_writes", 32'(writes - w0), 100);
        check_eq("stream_last_addr", 32'(last_addr), 76799);
        check_eq("stream_overflow", 32'(overflow), 0);

        // Clip counter saturates.
        for (int i = 0; i < 260; i++) drive_beat(400, 10, 0);
        check_eq("drop_saturate", 32'(drop_count), 32'(exp_drop));

        // Flush with a stuttering memory port.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(10 + i, 20, i + 1);
        flush_req = 1'b1;
        first_fd = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flush_done && first_fd < 0) first_fd = cyc;
            @(posedge clk);
            #1;
            mem_ready = ~mem_ready;
        end
        check_eq("flush_sb_empty", 32'(sb_q.size()), 0);
        check_eq("flush_done_timing", 32'(first_fd), 32'(last_wr_edge + 1));
        check_eq("flush_done_held", 32'(flush_done), 1);
        flush_req = 1'b0;
        tick(1);
        check_eq("flush_done_drop", 32'(flush_done), 0);

        // Overflow with a stalled memory port.
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_beat(i, 100, i);
        check_eq("full_in_ready", 32'(in_ready), 0);
        check_eq("full_fill", 32'(fill), 8);
        drive_beat(8, 100, 0);
        check_eq("ovf_flag", 32'(overflow), 32'(exp_ovf));
        check_eq("ovf_fill", 32'(fill), 8);
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
        tick(1);
        check_eq("ovf_drained", 32'(sb_q.size()), 0);
        check_eq("ovf_fill_after", 32'(fill), 0);

        // Asynchronous reset with beats buffered.
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_beat(50 + i, 60, 7);
        check_eq("pre_rst_fill", 32'(fill), 5);
        #5 resetn = 1'b0;
        #1;
        check_eq("arst_we", 32'(mem_we), 0);
        check_eq("arst_fill", 32'(fill), 0);
        check_eq("arst_overflow", 32'(overflow), 0);
        sb_q.delete();
        exp_ovf = 1'b0;
        exp_drop = 0;
        tick(2);
        resetn = 1'b1;
        mem_ready = 1'b1;
        tick(1);
        w0 = writes;
        drive_beat(10, 100, 6);
        tick(1);
        check_eq("post_rst_writes", 32'(writes - w0), 1);
        check_eq("post_rst_addr", 32'(last_addr), 32010);

`ifdef CLEAR_SCREEN_EN
        clear_color = 3'd5;
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        n = 0;
        while (n < 78000 && (clr_writes < 76800 || clear_busy)) begin
            tick(1);
            n++;
        end
        check_eq("clear_writes", 32'(clr_writes), 76800);
        check_eq("clear_bad", 32'(clr_bad), 0);
        check_eq("clear_busy_end", 32'(clear_busy), 0);
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sink end of the pixel-stream interface driven by the shape renderers: accepts (x, y, colour, writeEn) beats and commits them to the 320x240x3 framebuffer memory.
- Clips off-screen pixels and linearises coordinates to a 17-bit address.
- Buffers beats in a small FIFO because the framebuffer write port stalls while VGA scanout holds it.
- Provides a flush handshake so the top-level FSM knows when a shape is fully in memory.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, 2..64)
- SCREEN_W, 320, visible width; x >= SCREEN_W is clipped
- SCREEN_H, 240, visible height; y >= SCREEN_H is clipped

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- x_stream  in  9  pixel x
- y_stream  in  8  pixel y
- color_stream  in  3  pixel colour
- writeEn  in  1  beat valid
- in_ready  out  1  FIFO can accept a beat this cycle
- flush_req  in  1  level request to drain FIFO
- flush_done  out  1  FIFO empty and no write pending while flushing
- mem_addr  out  17  framebuffer address = y*SCREEN_W + x
- mem_wdata  out  3  framebuffer data
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write this cycle
- overflow  out  1  sticky: a valid in-range beat was lost
- drop_count  out  8  saturating count of clipped beats
- fill  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (resetn low, async): FIFO empty, fill=0, mem_we=0, mem_addr=0, mem_wdata=0, overflow=0, drop_count=0, flush_done=0, FSM=IDLE. Reset mid-burst discards buffered beats; no memory write occurs while resetn is low.
- Beat classification (each clk edge with writeEn=1):
  - in range (x<SCREEN_W and y<SCREEN_H) and in_ready=1: pushed.
  - out of range: discarded; drop_count+1, saturates at 255.
  - in range with FIFO full: discarded; overflow set. overflow stays set until reset.
- in_ready = !full.
  - No push-through on full: a push is refused even if a pop happens the same edge.
- Address: computed at push, so FIFO entries are {addr[16:0], colour[2:0]}.
  - y*SCREEN_W + x is evaluated at full 17-bit width with no truncation; max 76799.
- Memory side:
  - mem_we = !empty; mem_addr and mem_wdata show the FIFO head.
  - A write completes on an edge where mem_we && mem_ready; the head is then popped.
  - mem_addr and mem_wdata are held stable while mem_we=1 and mem_ready=0.
  - When the FIFO is empty, mem_addr and mem_wdata hold their last values.
- Latency: a beat pushed at edge N into an empty FIFO drives mem_we=1 during cycle N+1. With mem_ready=1 throughout, sustained throughput is one pixel per clock.
- Simultaneous push and pop with FIFO not full: occupancy is unchanged, order is preserved (FIFO strict ordering).
- Pointer wrap: read and write pointers carry 1 extra bit. full = MSBs differ and lower bits equal; empty = pointers equal.
- FSM:
  - IDLE -> DRAIN when flush_req=1.
  - DRAIN: pushes are still accepted. Go to DONE when the FIFO is empty (after the last write completes).
  - DONE: flush_done=1 (registered, asserted the cycle after the FIFO empties). Go to IDLE when flush_req=0; flush_done=0 in IDLE.
  - A new beat pushed while in DONE returns the FSM to DRAIN and drops flush_done.

Optional Feature:
- Macro: CLEAR_SCREEN_EN.
- When defined, adds ports clear_req (in, 1), clear_color (in, 3) and clear_busy (out, 1), plus FSM state CLEAR.
- Entry: a rising edge on clear_req in IDLE, after the FIFO is empty, enters CLEAR. Entry from DRAIN or DONE is not allowed.
- In CLEAR:
  - in_ready=0.
  - Addresses 0..76799 are written sequentially with clear_color, one per accepted write (mem_ready honoured).
  - clear_busy=1.
  - Returns to IDLE the cycle after address 76799 is accepted.
- When not defined, these ports and the state are absent and clear_req behaviour does not exist.

Test Plan:
- Single beat x=5, y=2, colour=3, mem_ready=1 -> next cycle mem_we=1, mem_addr=645, mem_wdata=3; fill back to 0 after that edge.
- x=320,y=0 and x=0,y=240 beats -> no mem_we, drop_count=2, overflow=0.
- mem_ready=0, push 9 in-range beats with DEPTH=8 -> first 8 accepted, in_ready=0 after 8th, overflow=1. Release mem_ready -> 8 writes in push order, addresses intact.
- Continuous 100-beat stream with mem_ready=1 -> 100 consecutive write cycles, no overflow, last address 319+239*320=76799 when the stream ends at (319,239).
- flush_req raised with 3 entries and mem_ready toggling 0/1 -> flush_done rises exactly one cycle after the 3rd write completes and falls after flush_req drops.
- resetn pulsed low with 5 entries buffered -> mem_we=0 immediately (async), fill=0, overflow=0. Post-reset single beat writes correctly. With CLEAR_SCREEN_EN: clear_req -> exactly 76800 writes of clear_color, then clear_busy=0.
